// File: rtl/prbs_gen_chk_pkg.sv
// prbs_pkg: shared types, constants and the LFSR step function for prbs_gen_chk.
// Provides the checker state enum, the default feedback mask and lfsr_adv().
// No ports; imported by lfsr_advance and prbs_gen_chk.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  localparam logic [15:0] PRBS_DEF_TAPS = 16'h002D;
  localparam int          PRBS_MAX_W    = 64;

  // Applies 'steps' Fibonacci steps to a 'width'-bit state held in the low
  // bits of a 64-bit word. The loop has a fixed bound so it unrolls cleanly;
  // only the first 'steps' iterations do anything.
  function automatic logic [63:0] lfsr_adv(input logic [63:0] state,
                                           input logic [63:0] taps,
                                           input int          steps,
                                           input int          width);
    logic [63:0] s;
    logic        fb;
    s = state;
    for (int i = 0; i < PRBS_MAX_W; i++) begin
      if (i < steps) begin
        fb = ^(s & taps);
        s  = (s >> 1) | (fb ? (64'd1 << (width - 1)) : 64'd0);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/prbs_gen_chk_if.sv
// prbs_gen_chk_if: generator and checker bus bundle for prbs_gen_chk.
// master = traffic source / consumer (bench or neighbouring blocks), slave = prbs_gen_chk.
// Signals: gen_en/gen_load/gen_seed/gen_data, chk_valid/chk_data/chk_clear,
// chk_locked/chk_err/chk_word_cnt/chk_err_cnt; err_inject only with PRBS_ERR_INJECT_EN.
interface prbs_gen_chk_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
);

  logic             gen_en;
  logic             gen_load;
  logic [WIDTH-1:0] gen_seed;
  logic [WIDTH-1:0] gen_data;
`ifdef PRBS_ERR_INJECT_EN
  logic             err_inject;
`endif
  logic             chk_valid;
  logic [WIDTH-1:0] chk_data;
  logic             chk_clear;
  logic             chk_locked;
  logic             chk_err;
  logic [CNT_W-1:0] chk_word_cnt;
  logic [CNT_W-1:0] chk_err_cnt;

`ifdef PRBS_ERR_INJECT_EN
  modport master (
    output gen_en, gen_load, gen_seed, err_inject, chk_valid, chk_data, chk_clear,
    input  gen_data, chk_locked, chk_err, chk_word_cnt, chk_err_cnt
  );
  modport slave (
    input  gen_en, gen_load, gen_seed, err_inject, chk_valid, chk_data, chk_clear,
    output gen_data, chk_locked, chk_err, chk_word_cnt, chk_err_cnt
  );
`else
  modport master (
    output gen_en, gen_load, gen_seed, chk_valid, chk_data, chk_clear,
    input  gen_data, chk_locked, chk_err, chk_word_cnt, chk_err_cnt
  );
  modport slave (
    input  gen_en, gen_load, gen_seed, chk_valid, chk_data, chk_clear,
    output gen_data, chk_locked, chk_err, chk_word_cnt, chk_err_cnt
  );
`endif

endinterface

// File: rtl/prbs_gen_chk_lfsr_advance.sv
// lfsr_advance: combinational STEP-fold advance of a WIDTH-bit Fibonacci LFSR.
// Ports: din (current state), dout (state after STEP single steps).
// Zero latency; no flow control.
module lfsr_advance
  import prbs_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(PRBS_DEF_TAPS),
  parameter int               STEP  = 16
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = WIDTH'(lfsr_adv(64'(din), 64'(TAPS), STEP, WIDTH));

endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: LFSR pattern generator plus self-synchronising pattern checker.
// Ports: clk, rst (sync, active-high), bus (prbs_gen_chk_if.slave). gen_data has
// no latency; checker outputs are registered, one cycle after the chk_valid word.
// Optional macro PRBS_ERR_INJECT_EN adds err_inject (flips gen_data bit 0 for one cycle).
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(PRBS_DEF_TAPS),
  parameter int               STEP     = 16,
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 8,
  parameter int               CNT_W    = 32
) (
  input logic           clk,
  input logic           rst,
  prbs_gen_chk_if.slave bus
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_CNT);

  // ---------------- generator ----------------
  logic [WIDTH-1:0] gen_state;
  logic [WIDTH-1:0] gen_next;

  lfsr_advance #(.WIDTH(WIDTH), .TAPS(TAPS), .STEP(STEP)) u_gen_adv (
    .din  (gen_state),
    .dout (gen_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      gen_state <= WIDTH'(1);
    end else if (bus.gen_en) begin
      if (bus.gen_load) begin
        // An all-zero seed would freeze the LFSR, so substitute 1.
        gen_state <= (bus.gen_seed == '0) ? WIDTH'(1) : bus.gen_seed;
      end else begin
        gen_state <= gen_next;
      end
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  // Corrupts only the presented word; gen_state keeps the true sequence.
  logic inj_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_q <= 1'b0;
    end else begin
      inj_q <= bus.err_inject & bus.gen_en & ~bus.gen_load;
    end
  end

  assign bus.gen_data = {gen_state[WIDTH-1:1], gen_state[0] ^ inj_q};
`else
  assign bus.gen_data = gen_state;
`endif

  // ---------------- checker ----------------
  chk_state_e       state;
  logic [WIDTH-1:0] exp_word;
  logic [WIDTH-1:0] adv_in;
  logic [WIDTH-1:0] adv_out;
  logic [GW-1:0]    good;
  logic [BW-1:0]    bad;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_q;
  logic             match;

  // In SEARCH the received word seeds the prediction; otherwise we roll exp forward.
  assign adv_in = (state == SEARCH) ? bus.chk_data : exp_word;
  assign match  = (bus.chk_data == exp_word);

  lfsr_advance #(.WIDTH(WIDTH), .TAPS(TAPS), .STEP(STEP)) u_chk_adv (
    .din  (adv_in),
    .dout (adv_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      exp_word <= WIDTH'(1);
      good     <= '0;
      bad      <= '0;
      word_cnt <= '0;
      err_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.chk_valid) begin
        case (state)
          SEARCH: begin
            if (bus.chk_data != '0) begin
              exp_word <= adv_out;
              good     <= '0;
              state    <= VERIFY;
            end
          end
          VERIFY: begin
            if (match) begin
              exp_word <= adv_out;
              good     <= good + GW'(1);
              if (good + GW'(1) == GOOD_LAST) begin
                state <= LOCKED;
                bad   <= '0;
              end
            end else begin
              state <= SEARCH;
            end
          end
          LOCKED: begin
            // Keep predicting through errors so isolated bit flips never force a resync.
            exp_word <= adv_out;
            if (word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
            if (match) begin
              bad <= '0;
            end else begin
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
              err_q <= 1'b1;
              bad   <= bad + BW'(1);
              if (bad + BW'(1) == BAD_LAST) state <= SEARCH;
            end
          end
          default: state <= SEARCH;
        endcase
      end
      // Clear wins over a same-cycle increment.
      if (bus.chk_clear) begin
        word_cnt <= '0;
        err_cnt  <= '0;
      end
    end
  end

  assign bus.chk_locked   = (state == LOCKED);
  assign bus.chk_err      = err_q;
  assign bus.chk_word_cnt = word_cnt;
  assign bus.chk_err_cnt  = err_cnt;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: scoreboard bench for prbs_gen_chk (STEP=16 checker instance A,
// STEP=1 generator instance B sharing A's generator controls). Expected outputs
// come from a behavioural model and are popped by a negedge monitor.
`timescale 1ns/1ps
module tb_prbs_gen_chk;

  localparam int W    = 16;
  localparam int CW   = 8;
  localparam int LOCK = 4;
  localparam int LOSS = 8;
  localparam logic [15:0] TAPS = 16'h002D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prbs_gen_chk_if #(.WIDTH(W), .CNT_W(CW)) ifa ();
  prbs_gen_chk_if #(.WIDTH(W), .CNT_W(32)) ifb ();

  prbs_gen_chk #(.WIDTH(W), .CNT_W(CW)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  prbs_gen_chk #(.WIDTH(W), .STEP(1))   u_dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  assign ifb.gen_en    = ifa.gen_en;
  assign ifb.gen_load  = ifa.gen_load;
  assign ifb.gen_seed  = ifa.gen_seed;
  assign ifb.chk_valid = 1'b0;
  assign ifb.chk_data  = '0;
  assign ifb.chk_clear = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
  assign ifb.err_inject = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [15:0] m_ga, m_gb, m_exp;
  logic        m_inj, m_err;
  int          m_mode, m_good, m_bad, m_wc, m_ec; // mode 0 search, 1 verify, 2 locked

  function automatic logic [15:0] ref_adv(input logic [15:0] s, input int n);
    logic [15:0] r;
    int          fb;
    r = s;
    for (int i = 0; i < n; i++) begin
      fb = $countones(r & TAPS) % 2;
      r  = (r >> 1) + (fb == 1 ? 16'h8000 : 16'h0000);
    end
    return r;
  endfunction

  function automatic logic [15:0] gen_out();
    return m_ga ^ {15'b0, m_inj};
  endfunction

  typedef struct {
    int          tgt;
    logic [15:0] ga;
    logic [15:0] gb;
    logic        lk;
    logic        er;
    logic [CW-1:0] wc;
    logic [CW-1:0] ec;
  } exp_t;

  exp_t sb_q[$];

  task automatic model_step(input logic inj);
    exp_t        e;
    logic [15:0] d;
    logic        mt;
    if (rst) begin
      m_ga = 16'h1; m_gb = 16'h1; m_inj = 1'b0; m_exp = 16'h1; m_err = 1'b0;
      m_mode = 0; m_good = 0; m_bad = 0; m_wc = 0; m_ec = 0;
    end else begin
      m_err = 1'b0;
      if (ifa.chk_valid) begin
        d  = ifa.chk_data;
        mt = (d == m_exp);
        if (m_mode == 0) begin
          if (d != 16'h0) begin m_exp = ref_adv(d, 16); m_good = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
          if (mt) begin
            m_exp = ref_adv(m_exp, 16);
            m_good++;
            if (m_good == LOCK) begin m_mode = 2; m_bad = 0; end
          end else m_mode = 0;
        end else begin
          m_exp = ref_adv(m_exp, 16);
          m_wc  = (m_wc < 255) ? m_wc + 1 : 255;
          if (mt) m_bad = 0;
          else begin
            m_ec  = (m_ec < 255) ? m_ec + 1 : 255;
            m_err = 1'b1;
            m_bad++;
            if (m_bad == LOSS) m_mode = 0;
          end
        end
      end
      if (ifa.chk_clear) begin m_wc = 0; m_ec = 0; end
`ifdef PRBS_ERR_INJECT_EN
      m_inj = inj & ifa.gen_en & ~ifa.gen_load;
`else
      m_inj = 1'b0 & inj;
`endif
      if (ifa.gen_en) begin
        if (ifa.gen_load) begin
          m_ga = (ifa.gen_seed == 16'h0) ? 16'h1 : ifa.gen_seed;
          m_gb = m_ga;
        end else begin
          m_ga = ref_adv(m_ga, 16);
          m_gb = ref_adv(m_gb, 1);
        end
      end
    end
    e.tgt = cyc + 1;
    e.ga  = gen_out();
    e.gb  = m_gb;
    e.lk  = (m_mode == 2);
    e.er  = m_err;
    e.wc  = CW'(m_wc);
    e.ec  = CW'(m_ec);
    sb_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].tgt <= cyc) begin
      e = sb_q.pop_front();
      check("gen_a",    64'(ifa.gen_data),     64'(e.ga));
      check("gen_b",    64'(ifb.gen_data),     64'(e.gb));
      check("locked",   64'(ifa.chk_locked),   64'(e.lk));
      check("err",      64'(ifa.chk_err),      64'(e.er));
      check("word_cnt", 64'(ifa.chk_word_cnt), 64'(e.wc));
      check("err_cnt",  64'(ifa.chk_err_cnt),  64'(e.ec));
      check("b_locked", 64'(ifb.chk_locked),   64'(ifb.chk_word_cnt | ifb.chk_err_cnt | 32'(ifb.chk_err)));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic en, input logic load, input logic [15:0] seed,
                       input logic vld, input logic [15:0] data, input logic clr, input logic inj);
    rst           = r;
    ifa.gen_en    = en;
    ifa.gen_load  = load;
    ifa.gen_seed  = seed;
    ifa.chk_valid = vld;
    ifa.chk_data  = data;
    ifa.chk_clear = clr;
`ifdef PRBS_ERR_INJECT_EN
    ifa.err_inject = inj;
`endif
    model_step(inj);
    @(posedge clk);
    #1;
  endtask

  task automatic lb(input logic [15:0] mask);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, gen_out() ^ mask, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic clr);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, clr, 1'b0);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] step1_exp [3];
  int          r;

  initial begin
    step1_exp[0] = 16'h8000; step1_exp[1] = 16'h4000; step1_exp[2] = 16'h2000;
    #1;
    // reset
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'h5555, 1'b1, 1'b0);
    check("rst_gen_b",  64'(ifb.gen_data), 64'h1);
    check("rst_locked", 64'(ifa.chk_locked), 64'h0);
    check("rst_wcnt",   64'(ifa.chk_word_cnt), 64'h0);

    // STEP=1 sequence and zero-seed load
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
      check("step1_seq", 64'(ifb.gen_data), 64'(step1_exp[i]));
    end
    drive(1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("zero_seed_b", 64'(ifb.gen_data), 64'h1);
    check("zero_seed_a", 64'(ifa.gen_data), 64'h1);

    // loopback acquisition
    for (int k = 1; k <= 10; k++) begin
      lb(16'h0);
      check("acq_locked", 64'(ifa.chk_locked), (k >= 5) ? 64'h1 : 64'h0);
    end
    check("acq_errcnt", 64'(ifa.chk_err_cnt), 64'h0);
    check("acq_wcnt",   64'(ifa.chk_word_cnt), 64'd5);

    // single bit error
    lb(16'h0100);
    check("flip_err",    64'(ifa.chk_err), 64'h1);
    check("flip_errcnt", 64'(ifa.chk_err_cnt), 64'h1);
    check("flip_locked", 64'(ifa.chk_locked), 64'h1);
    lb(16'h0);
    check("flip_next_err", 64'(ifa.chk_err), 64'h0);
    check("flip_next_cnt", 64'(ifa.chk_err_cnt), 64'h1);

    // loss of lock on a stuck word, then relock
    idle(1'b1);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h1234, 1'b0, 1'b0);
      check("loss_locked", 64'(ifa.chk_locked), (k < 8) ? 64'h1 : 64'h0);
    end
    check("loss_errcnt", 64'(ifa.chk_err_cnt), 64'd8);
    for (int k = 0; k < 5; k++) lb(16'h0);
    check("relock", 64'(ifa.chk_locked), 64'h1);

    // clear vs same-cycle counted mismatch
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, gen_out() ^ 16'h0001, 1'b1, 1'b0);
    check("clr_wcnt", 64'(ifa.chk_word_cnt), 64'h0);
    check("clr_ecnt", 64'(ifa.chk_err_cnt), 64'h0);

    // word counter saturation
    for (int k = 0; k < 260; k++) lb(16'h0);
    check("sat_wcnt", 64'(ifa.chk_word_cnt), 64'hFF);

`ifdef PRBS_ERR_INJECT_EN
    idle(1'b1);
    lb(16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, gen_out(), 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) lb(16'h0);
    check("inj_errcnt", 64'(ifa.chk_err_cnt), 64'h1);
    check("inj_locked", 64'(ifa.chk_locked), 64'h1);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1)       drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'($urandom), 1'b0, 1'b0);
      else if (r < 4)  drive(1'b0, 1'b1, 1'b1, ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                             1'b0, 16'h0, 1'b0, 1'b0);
      else if (r < 7)  drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, gen_out(), 1'b1, 1'b0);
      else if (r < 12) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'b1, 16'($urandom), 1'b0, 1'b0);
      else if (r < 20) lb(16'(32'd1 << $urandom_range(0, 15)));
      else if (r < 30) drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      else if (r < 33) drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, gen_out(), 1'b0, 1'b1);
      else             lb(16'h0);
    end

    // reset while in VERIFY
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) lb(16'h0);
    for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h1234, 1'b0, 1'b0);
    check("pre_wcnt", 64'(ifa.chk_word_cnt), 64'd12);
    check("pre_ecnt", 64'(ifa.chk_err_cnt), 64'd8);
    lb(16'h0);
    lb(16'h0);
    check("verify_locked", 64'(ifa.chk_locked), 64'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, gen_out(), 1'b0, 1'b0);
    check("vrst_locked", 64'(ifa.chk_locked), 64'h0);
    check("vrst_wcnt",   64'(ifa.chk_word_cnt), 64'h0);
    check("vrst_ecnt",   64'(ifa.chk_err_cnt), 64'h0);
    check("vrst_gen_a",  64'(ifa.gen_data), 64'h1);

    idle(1'b0);
    idle(1'b0);
    @(posedge clk);
    #1;
    check("sb_drain", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
- Parametrised Fibonacci-LFSR pattern generator plus self-synchronising pattern checker for link and datapath speed testing.
- The generator advances STEP LFSR steps per enabled cycle and emits the full state as a word.
- The checker locks onto a received word stream produced by an identical generator, then counts word errors.
- Sits beside the packet builder (generator side) and the packet parser (checker side).

Parameters:
- WIDTH, 16: LFSR state and data word width in bits; legal range 4..64.
- TAPS, 16'h002D: feedback mask. fb = XOR-reduce(state & TAPS). One step is state <= {fb, state[WIDTH-1:1]}.
- STEP, 16: LFSR steps per enabled cycle; legal range 1..WIDTH.
- LOCK_CNT, 4: consecutive matching words needed in VERIFY to declare lock; must be >= 1.
- LOSS_CNT, 8: consecutive mismatching words in LOCKED that drop lock; must be >= 1.
- CNT_W, 32: width of the word and error counters.

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- gen_en  in  1  advance the generator this cycle
- gen_load  in  1  with gen_en: load gen_seed instead of advancing
- gen_seed  in  WIDTH  seed value
- gen_data  out  WIDTH  current generator state
- chk_valid  in  1  chk_data is presented this cycle
- chk_data  in  WIDTH  received word
- chk_clear  in  1  zero both counters; lock state is unaffected
- chk_locked  out  1  high in LOCKED
- chk_err  out  1  one-cycle pulse, registered: mismatch seen in LOCKED
- chk_word_cnt  out  CNT_W  valid words checked while LOCKED, saturating
- chk_err_cnt  out  CNT_W  mismatching words while LOCKED, saturating

Behaviour:
- adv(s) means STEP single steps applied to s; it is combinational.
- Generator:
  - rst: state <= 1.
  - gen_en & gen_load: state <= gen_seed, except a seed of all-zeros stores 1 (avoids lock-up).
  - gen_en & !gen_load: state <= adv(state).
  - !gen_en: hold.
  - gen_data = state, with no extra latency.
- Checker FSM, states SEARCH, VERIFY, LOCKED. Reset puts it in SEARCH with exp=1, good=0, bad=0, counters 0, chk_locked=0, chk_err=0.
- Cycles without chk_valid change nothing except chk_clear and the chk_err pulse returning to 0.
- SEARCH, on chk_valid:
  - all-zero chk_data: ignored.
  - otherwise: exp <= adv(chk_data), good <= 0, go to VERIFY.
- VERIFY, on chk_valid:
  - chk_data==exp: exp <= adv(exp), good++. If good+1==LOCK_CNT, go to LOCKED with bad=0.
  - mismatch: go to SEARCH. That word is not reused for seeding.
- LOCKED, on chk_valid:
  - exp <= adv(exp) regardless of match, so a single bit error never causes a resync.
  - chk_word_cnt++.
  - match: bad <= 0.
  - mismatch: chk_err_cnt++, chk_err=1 next cycle, bad++. If bad+1==LOSS_CNT, go to SEARCH.
- chk_locked is registered and rises the cycle after the LOCK_CNT-th match.
- Counters saturate at all-ones.
- chk_clear has priority over an increment in the same cycle, so the counter ends at 0.
- rst mid-operation restores all reset values on the next edge, regardless of other inputs.

Optional Feature:
- Macro: PRBS_ERR_INJECT_EN.
- Defined:
  - Adds input port err_inject (1 bit).
  - When err_inject & gen_en & !gen_load: gen_data bit 0 is inverted for the following cycle only (the output word after the advance). The internal state stays correct.
  - Injection requests with gen_en low are dropped.
- Undefined: the port does not exist and gen_data always equals state.

Decomposition:
- Package prbs_pkg holds:
  - the checker state enum (SEARCH, VERIFY, LOCKED);
  - the default TAPS constant 16'h002D;
  - function lfsr_adv(state, taps, steps), which is a loop of single steps.
- One sub-module, lfsr_advance: combinational, parameters WIDTH/TAPS/STEP. It is instantiated twice, for the generator and for the checker's exp/seed path.

Test Plan:
- Instance with STEP=1:
  - after rst, gen_en for 3 cycles: gen_data 0x0001 -> 0x8000 -> 0x4000 -> 0x2000.
  - gen_load with seed 0x0000: gen_data becomes 0x0001.
- Default instance, loopback gen_data->chk_data with chk_valid=gen_en for 10 cycles: chk_locked rises after word 5 (1 seed word + 4 matches). chk_err_cnt stays 0.
- While locked, flip one bit of one word: chk_err pulses once, chk_err_cnt=1, chk_locked stays 1, the next word matches.
- While locked, force chk_data=0x1234 for 8 words: chk_err_cnt=8, chk_locked drops after the 8th word, then relock occurs within 5 good words.
- chk_clear asserted on the same cycle as a counted mismatch: both counters read 0.
- rst asserted in VERIFY: chk_locked=0, counters 0, and gen_data=0x0001 on the next cycle.
- With PRBS_ERR_INJECT_EN: one err_inject pulse in loopback gives chk_err_cnt=1 and lock is retained.
